// File: rtl/pulse_train_pkg.sv
// Shared definitions for the pulse-train generator: FSM state encodings.
// Widths stay as module parameters so the package carries no sizing.
package pulse_train_pkg;

    localparam logic [1:0] ENC_IDLE = 2'd0;
    localparam logic [1:0] ENC_ON   = 2'd1;
    localparam logic [1:0] ENC_OFF  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ENC_IDLE,
        ON   = ENC_ON,
        OFF  = ENC_OFF
    } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Prescaler: emits tick once every scale+1 clocks while clr is low.
// The timer is compared before increment, so an all-ones scale needs no extra bit.
module tick_prescaler #(
    parameter int PRE_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 sclr,
    input  logic                 clr,
    input  logic [PRE_WIDTH-1:0] scale,
    output logic                 tick
);

    logic [PRE_WIDTH-1:0] timer_q;
    logic [PRE_WIDTH-1:0] timer_d;

    assign tick = (timer_q == scale);

    // Next timer value: wrap on tick, hold at zero while cleared.
    always_comb begin
        timer_d = timer_q + PRE_WIDTH'(1);
        if (clr || tick) begin
            timer_d = '0;
        end
    end

    // Timer register with synchronous clear.
    always_ff @(posedge clk) begin
        if (sclr) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/pulse_train_gen.sv
// Programmable pulse-train source: num high pulses of (on_len+1)*(scale+1)
// clocks separated by low gaps of (off_len+1)*(scale+1) clocks.
// num=0 runs until stop. pulse, busy and done all come straight from flops.
module pulse_train_gen #(
    parameter int WIDTH     = 16,
    parameter int PRE_WIDTH = 16,
    parameter int NUM_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 sclr,
    input  logic                 start,
    input  logic                 stop,
    input  logic [PRE_WIDTH-1:0] scale,
    input  logic [WIDTH-1:0]     on_len,
    input  logic [WIDTH-1:0]     off_len,
    input  logic [NUM_WIDTH-1:0] num,
    output logic                 pulse,
    output logic                 busy,
    output logic                 done,
    output logic [NUM_WIDTH-1:0] pulse_cnt
);

    import pulse_train_pkg::*;

    state_e               state_q, state_d;
    logic                 pulse_q, pulse_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 stop_pend_q, stop_pend_d;
    logic [NUM_WIDTH-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [WIDTH-1:0]     cnt_q, cnt_d;
    logic [PRE_WIDTH-1:0] scale_l_q, scale_l_d;
    logic [WIDTH-1:0]     on_len_l_q, on_len_l_d;
    logic [WIDTH-1:0]     off_len_l_q, off_len_l_d;
    logic [NUM_WIDTH-1:0] num_l_q, num_l_d;

    logic                 tick;
    logic                 phase_end;
    logic                 presc_clr;
    logic [WIDTH-1:0]     cur_len;
    logic [NUM_WIDTH-1:0] pulse_cnt_inc;

    assign cur_len       = (state_q == ON) ? on_len_l_q : off_len_l_q;
    assign phase_end     = tick && (cnt_q == cur_len);
    assign pulse_cnt_inc = pulse_cnt_q + NUM_WIDTH'(1);
    // Keep the tick grid aligned to the start of every phase.
    assign presc_clr     = (state_q == IDLE) || phase_end;

    tick_prescaler #(
        .PRE_WIDTH (PRE_WIDTH)
    ) u_prescaler (
        .clk   (clk),
        .sclr  (sclr),
        .clr   (presc_clr),
        .scale (scale_l_q),
        .tick  (tick)
    );

    // Next-state and registered-output logic for the IDLE/ON/OFF sequencer.
    always_comb begin
        state_d     = state_q;
        pulse_d     = pulse_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        stop_pend_d = stop_pend_q;
        pulse_cnt_d = pulse_cnt_q;
        cnt_d       = cnt_q;
        scale_l_d   = scale_l_q;
        on_len_l_d  = on_len_l_q;
        off_len_l_d = off_len_l_q;
        num_l_d     = num_l_q;

        case (state_q)
            IDLE: begin
                stop_pend_d = 1'b0;
                if (start && !stop) begin
                    scale_l_d   = scale;
                    on_len_l_d  = on_len;
                    off_len_l_d = off_len;
                    num_l_d     = num;
                    pulse_cnt_d = '0;
                    cnt_d       = '0;
                    state_d     = ON;
                    pulse_d     = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            ON: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (tick) begin
                    if (phase_end) begin
                        cnt_d       = '0;
                        pulse_cnt_d = pulse_cnt_inc;
                        pulse_d     = 1'b0;
                        // A stop seen on the final ON cycle still counts as pending.
                        if (((num_l_q != '0) && (pulse_cnt_inc == num_l_q)) ||
                            stop_pend_q || stop) begin
                            state_d     = IDLE;
                            busy_d      = 1'b0;
                            done_d      = 1'b1;
                            stop_pend_d = 1'b0;
                        end else begin
                            state_d = OFF;
                        end
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end
            end
            OFF: begin
                // Pulse is already low, so a stop here can end the train at once.
                if (stop) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (tick) begin
                    if (phase_end) begin
                        cnt_d   = '0;
                        state_d = ON;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pulse_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q     <= IDLE;
            pulse_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            pulse_cnt_q <= '0;
            cnt_q       <= '0;
            scale_l_q   <= '0;
            on_len_l_q  <= '0;
            off_len_l_q <= '0;
            num_l_q     <= '0;
        end else begin
            state_q     <= state_d;
            pulse_q     <= pulse_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            stop_pend_q <= stop_pend_d;
            pulse_cnt_q <= pulse_cnt_d;
            cnt_q       <= cnt_d;
            scale_l_q   <= scale_l_d;
            on_len_l_q  <= on_len_l_d;
            off_len_l_q <= off_len_l_d;
            num_l_q     <= num_l_d;
        end
    end

    assign pulse     = pulse_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pulse_cnt = pulse_cnt_q;

endmodule

// File: doc/pulse_train_gen.md
Name: pulse_train_gen

Overview:
- Programmable pulse-train source: emits `num` high pulses on `pulse`, separated by low gaps.
- High and low durations are set in prescaled ticks, using the same (len+1)*(scale+1) convention as the start/stop window timer.
- This is the transmit end of the start/stop timing path. It drives stimulus into the start/stop window timer and generator/actuator control inputs.

Parameters:
- WIDTH, 16, width of on_len/off_len phase counters
- PRE_WIDTH, 16, width of prescaler `scale`
- NUM_WIDTH, 16, width of pulse-count `num`

Ports:
- clk  input  1  system clock
- sclr  input  1  synchronous active-high reset
- start  input  1  request a new train; accepted only when busy=0
- stop  input  1  graceful abort request (level or pulse)
- scale  input  PRE_WIDTH  prescaler; tick period = scale+1 clocks
- on_len  input  WIDTH  high phase = (on_len+1) ticks
- off_len  input  WIDTH  low phase = (off_len+1) ticks
- num  input  NUM_WIDTH  pulses per train; 0 = continuous until stop
- pulse  output  1  generated signal, registered
- busy  output  1  train in progress (ON or OFF state)
- done  output  1  one-clock strobe when a train ends
- pulse_cnt  output  NUM_WIDTH  completed high phases in the current/last train

Behaviour:
- One clock, clk. Reset is synchronous and active-high on sclr.
- While sclr=1: state=IDLE, pulse=0, busy=0, done=0, pulse_cnt=0, timer=0, cnt=0. sclr overrides all other inputs.
- sclr asserted mid-train: outputs go to reset values on the next edge. No done strobe is issued.
- FSM states: IDLE, ON, OFF.
- IDLE:
  - start && !stop latches scale/on_len/off_len/num into *_l registers.
  - Clears pulse_cnt, timer and cnt, then moves to ON.
  - pulse=1 and busy=1 on the clock after start (latency 1).
  - start && stop together in IDLE: ignored, stays IDLE.
- Input changes after acceptance have no effect until the next start.
- start while busy: ignored.
- Prescaler:
  - In ON/OFF, timer increments each clock.
  - tick = (timer==scale_l); on tick, timer<=0.
  - scale_l=0 gives a tick every clock.
- Phase counter: cnt increments on tick. The phase ends on the tick where cnt==len_l, after which cnt<=0 and timer<=0.
- Durations are exact: ON lasts (on_len_l+1)*(scale_l+1) clocks; OFF lasts (off_len_l+1)*(scale_l+1) clocks.
- End of ON:
  - pulse_cnt increments (wraps modulo 2^NUM_WIDTH in continuous mode).
  - If (num_l!=0 && pulse_cnt+1==num_l) or stop_pend: go IDLE, pulse=0, busy=0, done=1 for one clock.
  - Otherwise go OFF with pulse=0.
- The last pulse is not followed by an OFF gap.
- End of OFF: go ON with pulse=1. No dead cycle between phases.
- stop handling:
  - stop during ON sets stop_pend. The current high phase completes fully (no runt pulse), then the train ends with done.
  - stop during OFF ends the train on the next clock: IDLE, busy=0, done=1, pulse stays 0.
  - stop on the same cycle as an ON-end: treated as stop_pend, so the train ends there.
- stop_pend is cleared on entry to IDLE.
- done and start on the same cycle: start is accepted on that cycle because busy is already 0.
- Maximum-value boundaries: on_len/off_len/scale = all-ones must work without overflow. Counters are compared before increment; no extra width is needed.
- pulse is driven directly from a flop (glitch-free), so it is safe to route off-chip.

Decomposition:
- Shared package pulse_train_pkg: state enum typedef (IDLE, ON, OFF) and localparam encodings. Widths remain module parameters.
- One natural sub-module, tick_prescaler:
  - Inputs: clk, sclr, clr, scale.
  - Output: tick.
  - Cleared by clr at phase boundaries and in IDLE.
  - The start/stop window timer can later reuse the same prescaler.

Test Plan:
- scale=1, on_len=2, off_len=1, num=3, start at t0:
  - pulse high on t1..t6, low t7..t10, high t11..t16, low t17..t20, high t21..t26.
  - done=1 at t27, pulse_cnt=3, total busy 26 clocks.
- scale=0, on_len=0, off_len=0, num=2: pulse 1,0,1 on consecutive clocks, then done. Checks minimum phases and no dead cycles.
- num=0 (continuous), scale=0, on_len=3, off_len=3: square wave of period 8. Assert stop mid-high → that high phase completes to 4 clocks, then done; stop mid-low → done on the next clock.
- sclr asserted during the second ON phase: pulse/busy/pulse_cnt are 0 on the next clock with no done strobe; a new start then behaves identically to a fresh train.
- start held high continuously with num=1, on_len=1, scale=0: trains restart back-to-back. done and the new acceptance occur on the same cycle; parameter changes while busy do not alter the running train.
- Loopback: drive the start/stop window timer's sig from pulse with matching scale/length. Its enable window must match the pulse high width cycle-for-cycle.
